// File: rtl/payload_pkg.sv
// payload_pkg: types, class indices and the character-class table shared by
// the payload decoder and the engine array.
// Build option used by the consumers: PAYLOAD_CASE_FOLD_EN folds A-Z onto
// a-z before the class lookup.
package payload_pkg;

    // Number of class lines the engine array is generated against.
    localparam int NUM_CLASS_DEF = 40;

    // Decoder FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SOD    = 2'd1,
        STREAM = 2'd2,
        EOD    = 2'd3
    } payload_state_e;

    // Named class indices; the index is the `in_k` line number at the engines.
    localparam int CLS_X        = 0;   // 'X'
    localparam int CLS_O        = 1;   // 'O'
    localparam int CLS_COLON    = 2;   // ':'
    localparam int CLS_NOT_CRLF = 3;   // anything but CR / LF
    localparam int CLS_DIGIT    = 4;   // 0-9
    localparam int CLS_UPPER    = 5;   // A-Z
    localparam int CLS_LOWER    = 6;   // a-z
    localparam int CLS_SPACE    = 7;   // space or tab
    localparam int CLS_DASH     = 8;   // '-'
    localparam int CLS_LOWER_O  = 9;   // 'o'
    localparam int CLS_LOWER_X  = 10;  // 'x'
    localparam int CLS_PRINT    = 11;  // 0x20-0x7E
    localparam int CLS_HEX      = 12;  // 0-9 a-f A-F
    localparam int CLS_ALNUM    = 13;  // 0-9 a-z A-Z
    localparam int CLS_PUNCT    = 14;  // printable, not alnum, not space
    localparam int CLS_CR       = 15;  // 0x0D
    localparam int CLS_LF       = 16;  // 0x0A
    localparam int CLS_NUL      = 17;  // 0x00
    localparam int CLS_HIGH     = 18;  // 0x80-0xFF
    localparam int CLS_SLASH    = 19;  // '/'
    localparam int CLS_DOT      = 20;  // '.'
    localparam int CLS_EQ       = 21;  // '='
    localparam int CLS_LOWER_P  = 22;  // 'p'
    localparam int CLS_UPPER_S  = 23;  // 'S'
    localparam int CLS_BIT_BASE = 24;  // 24..31: byte bit (k-24) set
    localparam int CLS_NIB_BASE = 32;  // 32..39: low nibble == (k-32)

    // Membership of byte b in class k; classes beyond the table are empty.
    function automatic logic class_member(input int k, input logic [7:0] b);
        logic [7:0] sh;
        logic       is_dig;
        logic       is_up;
        logic       is_lo;
        logic       is_prn;
        logic       r;
        is_dig = (b >= 8'h30) && (b <= 8'h39);
        is_up  = (b >= 8'h41) && (b <= 8'h5A);
        is_lo  = (b >= 8'h61) && (b <= 8'h7A);
        is_prn = (b >= 8'h20) && (b <= 8'h7E);
        sh     = '0;
        r      = 1'b0;
        case (k)
            CLS_X:        r = (b == 8'h58);
            CLS_O:        r = (b == 8'h4F);
            CLS_COLON:    r = (b == 8'h3A);
            CLS_NOT_CRLF: r = (b != 8'h0A) && (b != 8'h0D);
            CLS_DIGIT:    r = is_dig;
            CLS_UPPER:    r = is_up;
            CLS_LOWER:    r = is_lo;
            CLS_SPACE:    r = (b == 8'h20) || (b == 8'h09);
            CLS_DASH:     r = (b == 8'h2D);
            CLS_LOWER_O:  r = (b == 8'h6F);
            CLS_LOWER_X:  r = (b == 8'h78);
            CLS_PRINT:    r = is_prn;
            CLS_HEX:      r = is_dig || ((b >= 8'h61) && (b <= 8'h66)) ||
                              ((b >= 8'h41) && (b <= 8'h46));
            CLS_ALNUM:    r = is_dig || is_up || is_lo;
            CLS_PUNCT:    r = is_prn && !(is_dig || is_up || is_lo) && (b != 8'h20);
            CLS_CR:       r = (b == 8'h0D);
            CLS_LF:       r = (b == 8'h0A);
            CLS_NUL:      r = (b == 8'h00);
            CLS_HIGH:     r = b[7];
            CLS_SLASH:    r = (b == 8'h2F);
            CLS_DOT:      r = (b == 8'h2E);
            CLS_EQ:       r = (b == 8'h3D);
            CLS_LOWER_P:  r = (b == 8'h70);
            CLS_UPPER_S:  r = (b == 8'h53);
            default: begin
                if ((k >= CLS_BIT_BASE) && (k < CLS_BIT_BASE + 8)) begin
                    sh = b >> (k - CLS_BIT_BASE);
                    r  = sh[0];
                end else if ((k >= CLS_NIB_BASE) && (k < CLS_NIB_BASE + 8)) begin
                    r = (int'(b[3:0]) == (k - CLS_NIB_BASE));
                end
            end
        endcase
        return r;
    endfunction

    // CLASS_TABLE[b]: full membership vector of byte b.
    function automatic logic [NUM_CLASS_DEF-1:0] class_table(input logic [7:0] b);
        logic [NUM_CLASS_DEF-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CLASS_DEF; k++) begin
            v = v | (NUM_CLASS_DEF'(class_member(k, b)) << k);
        end
        return v;
    endfunction

endpackage

// File: rtl/payload_class_lut.sv
// payload_class_lut: combinational byte -> class membership vector.
// Build option: PAYLOAD_CASE_FOLD_EN maps A-Z onto a-z before the lookup so
// case-insensitive rules only need lower-case classes.
module payload_class_lut
    import payload_pkg::*;
#(
    parameter int NUM_CLASS = NUM_CLASS_DEF
) (
    input  logic [7:0]           i_byte,
    output logic [NUM_CLASS-1:0] o_class
);

    logic [7:0] w_byte;

    // Lookup key: raw byte, or the byte folded to lower case.
    always_comb begin
`ifdef PAYLOAD_CASE_FOLD_EN
        if ((i_byte >= 8'h41) && (i_byte <= 8'h5A)) begin
            w_byte = i_byte | 8'h20;
        end else begin
            w_byte = i_byte;
        end
`else
        w_byte = i_byte;
`endif
    end

    // One membership decoder per class line.
    for (genvar k = 0; k < NUM_CLASS; k++) begin : g_cls
        assign o_class[k] = class_member(k, w_byte);
    end

endmodule

// File: rtl/payload_char_decoder.sv
// payload_char_decoder: serialises 64-bit payload words to one byte per cycle
// and drives the shared sod / en / class lines of the engine array, plus the
// end-of-data pulse and payload length for the match collector.
// Build option: PAYLOAD_CASE_FOLD_EN (case fold inside payload_class_lut).
//
// Input handshake: a word transfers on a clock edge where s_tvalid and
// s_tready are both 1; s_tready depends only on registered state (and rst),
// never on s_tvalid. s_tready is high in IDLE and during the last-lane cycle
// (or stall) of a non-tlast word, so the next word of a packet prefetches
// with no bubble.
module payload_char_decoder
    import payload_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int NUM_CLASS = NUM_CLASS_DEF,
    parameter int LEN_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic [DATA_W/8-1:0]   s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic                  sod,
    output logic                  en,
    output logic [NUM_CLASS-1:0]  class_vec,
    output logic                  eod,
    output logic [LEN_W-1:0]      pkt_len,
    output payload_state_e        dbg_state
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    // Registered state.
    payload_state_e        r_state;
    logic [DATA_W-1:0]     r_data;
    logic [LANES-1:0]      r_keep;
    logic                  r_last;
    logic [LANE_W-1:0]     r_lane;    // lane currently shown on en/class_vec
    logic                  r_stall;   // waiting for the next word of a packet
    logic [LEN_W-1:0]      r_cnt;
    logic                  r_en;
    logic [NUM_CLASS-1:0]  r_class;

    // Next-state / datapath controls.
    payload_state_e        w_state_nxt;
    logic [LANE_W-1:0]     w_lane_nxt;
    logic                  w_stall_nxt;
    logic                  w_load;       // capture the input word into the buffer
    logic                  w_cnt_clr;
    logic                  w_issue;      // a lane is presented next cycle
    logic                  w_issue_keep;
    logic [7:0]            w_issue_byte;
    logic [LANE_W-1:0]     w_lane_inc;
    logic [DATA_W-1:0]     w_buf_shift;
    logic [NUM_CLASS-1:0]  w_lut_class;
    logic                  w_ready;
    logic                  w_hs;

    assign w_hs        = s_tvalid && w_ready;
    assign w_lane_inc  = r_lane + LANE_W'(1);
    assign w_buf_shift = r_data >> {w_lane_inc, 3'b000};

    payload_class_lut #(
        .NUM_CLASS (NUM_CLASS)
    ) u_lut (
        .i_byte  (w_issue_byte),
        .o_class (w_lut_class)
    );

    // State register and the registered en / class_vec / byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_lane  <= '0;
            r_stall <= 1'b0;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_class <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lane  <= w_lane_nxt;
            r_stall <= w_stall_nxt;
            if (w_load) begin
                r_data <= s_tdata;
                r_keep <= s_tkeep;
                r_last <= s_tlast;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_issue && w_issue_keep && (r_cnt != {LEN_W{1'b1}})) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
            r_en    <= w_issue && w_issue_keep;
            r_class <= (w_issue && w_issue_keep) ? w_lut_class : '0;
        end
    end

    // Next state, and which byte (if any) is presented on the following cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_lane_nxt   = r_lane;
        w_stall_nxt  = r_stall;
        w_load       = 1'b0;
        w_cnt_clr    = 1'b0;
        w_issue      = 1'b0;
        w_issue_keep = 1'b0;
        w_issue_byte = '0;
        unique case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_load      = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_lane_nxt  = '0;
                    w_stall_nxt = 1'b0;
                    w_state_nxt = SOD;
                end
            end
            SOD: begin
                // Lane 0 is fetched here so it lands the cycle after sod.
                w_state_nxt  = STREAM;
                w_issue      = 1'b1;
                w_issue_byte = r_data[7:0];
                w_issue_keep = r_keep[0];
            end
            STREAM: begin
                if (!r_stall && (r_lane != LAST_LANE)) begin
                    w_lane_nxt   = w_lane_inc;
                    w_issue      = 1'b1;
                    w_issue_byte = w_buf_shift[7:0];
                    w_issue_keep = r_keep[w_lane_inc];
                end else if (r_last) begin
                    w_state_nxt = EOD;
                end else if (w_hs) begin
                    // Prefetched word: its lane 0 bypasses the buffer.
                    w_load       = 1'b1;
                    w_lane_nxt   = '0;
                    w_stall_nxt  = 1'b0;
                    w_issue      = 1'b1;
                    w_issue_byte = s_tdata[7:0];
                    w_issue_keep = s_tkeep[0];
                end else begin
                    w_stall_nxt = 1'b1;
                end
            end
            EOD: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        w_ready = 1'b0;
        if (!rst) begin
            if (r_state == IDLE) begin
                w_ready = 1'b1;
            end else if ((r_state == STREAM) && (r_lane == LAST_LANE) && !r_last) begin
                w_ready = 1'b1;
            end
        end
        s_tready  = w_ready;
        sod       = (r_state == SOD);
        eod       = (r_state == EOD);
        pkt_len   = (r_state == EOD) ? r_cnt : '0;
        en        = r_en;
        class_vec = r_class;
        dbg_state = r_state;
    end

endmodule

// File: tb/tb_payload_char_decoder.sv
// tb_payload_char_decoder: directed and random packets against a byte-level
// model of the decoder; expected events are queued with the cycle on which
// they must appear and checked by an independent monitor.
module tb_payload_char_decoder;
    import payload_pkg::*;

    localparam int DATA_W    = 64;
    localparam int NUM_CLASS = 40;
    localparam int LEN_W     = 16;
    localparam int LANES     = DATA_W / 8;
    localparam int QW        = 2 + 32 + NUM_CLASS;
    localparam logic [1:0] K_SOD = 2'd0;
    localparam logic [1:0] K_EN  = 2'd1;
    localparam logic [1:0] K_EOD = 2'd2;

    logic                 clk;
    logic                 rst;
    logic [DATA_W-1:0]    s_tdata;
    logic [LANES-1:0]     s_tkeep;
    logic                 s_tlast;
    logic                 s_tvalid;
    logic                 s_tready;
    logic                 sod;
    logic                 en;
    logic [NUM_CLASS-1:0] class_vec;
    logic                 eod;
    logic [LEN_W-1:0]     pkt_len;
    payload_state_e       dbg_state;

    // Entry: {kind, cycle the event must appear on, class vector or length}.
    logic [QW-1:0] exp_q[$];

    int n_vec      = 0;
    int n_err      = 0;
    int cyc        = 0;
    int exp_free   = 0;   // earliest cycle the DUT may accept the next word
    bit in_pkt     = 1'b0;
    int cur_len    = 0;
    int last_lane0 = 0;

    payload_char_decoder #(
        .DATA_W    (DATA_W),
        .NUM_CLASS (NUM_CLASS),
        .LEN_W     (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .sod       (sod),
        .en        (en),
        .class_vec (class_vec),
        .eod       (eod),
        .pkt_len   (pkt_len),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the class vector the engines should see for a payload byte.
    function automatic logic [NUM_CLASS-1:0] model_class(input logic [7:0] b);
        logic [7:0] c;
        c = b;
`ifdef PAYLOAD_CASE_FOLD_EN
        if ((c >= 8'h41) && (c <= 8'h5A)) c = c + 8'd32;
`endif
        return class_table(c);
    endfunction

    task automatic push_exp(input logic [1:0] kind, input int c, input logic [NUM_CLASS-1:0] v);
        exp_q.push_back({kind, 32'(c), v});
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if ({sod, en, eod, s_tready} !== 4'b0000 || class_vec !== '0 || pkt_len !== '0) begin
            n_err++;
            $display("FAIL %s got sod=%0b en=%0b eod=%0b s_tready=%0b class_vec=%h pkt_len=%0d required all 0",
                     tag, sod, en, eod, s_tready, class_vec, pkt_len);
        end
    endtask

    // Drive one word; extra > 0 holds s_tvalid low that many cycles past the
    // point where the DUT first becomes ready for a mid-packet word.
    task automatic send_word(input logic [DATA_W-1:0] d, input logic [LANES-1:0] k,
                             input bit last, input int extra);
        int p;
        int hs;
        int lane0;
        int exp_hs;
        int waited;
        bit first;
        logic [DATA_W-1:0] sh;
        first = !in_pkt;
        if (in_pkt && extra > 0) begin
            while (cyc < exp_free + extra) begin
                @(posedge clk);
                #1;
            end
        end
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = last;
        s_tvalid = 1'b1;
        p        = cyc;
        waited   = 0;
        @(negedge clk);
        while (!s_tready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (!s_tready) begin
            n_err++;
            $display("FAIL ready_timeout cycle=%0d got s_tready=0 required 1 within 100 cycles", cyc);
            @(posedge clk);
            #1;
            s_tvalid = 1'b0;
            return;
        end
        hs     = cyc;
        exp_hs = (p > exp_free) ? p : exp_free;
        if (hs != exp_hs) begin
            n_err++;
            $display("FAIL ready_timing got handshake cycle=%0d required cycle=%0d", hs, exp_hs);
        end
        if (first) push_exp(K_SOD, hs + 1, '0);
        lane0      = first ? hs + 2 : hs + 1;
        last_lane0 = lane0;
        sh         = d;
        for (int l = 0; l < LANES; l++) begin
            if (k[l]) begin
                push_exp(K_EN, lane0 + l, model_class(sh[7:0]));
                if (cur_len < (1 << LEN_W) - 1) cur_len++;
            end
            sh = sh >> 8;
        end
        if (last) begin
            push_exp(K_EOD, lane0 + LANES, NUM_CLASS'(cur_len));
            exp_free = lane0 + LANES + 1;
            in_pkt   = 1'b0;
            cur_len  = 0;
        end else begin
            exp_free = lane0 + LANES - 1;
            in_pkt   = 1'b1;
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tdata  = {$urandom, $urandom};
        s_tkeep  = 8'($urandom);
        s_tlast  = 1'($urandom);
    endtask

    task automatic mon_pop(input logic [1:0] kind, input logic [NUM_CLASS-1:0] got, input string name);
        logic [QW-1:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s cycle=%0d got unexpected event value=%h required no event", name, cyc, got);
            return;
        end
        e = exp_q.pop_front();
        if (e[QW-1 -: 2] != kind || int'(e[QW-3 -: 32]) != cyc || e[NUM_CLASS-1:0] != got) begin
            n_err++;
            $display("FAIL %s got kind=%0d cycle=%0d value=%h required kind=%0d cycle=%0d value=%h",
                     name, kind, cyc, got, e[QW-1 -: 2], e[QW-3 -: 32], e[NUM_CLASS-1:0]);
        end
    endtask

    // Monitor: strobe exclusivity, idle class lines, and in-order event checks.
    always @(negedge clk) begin
        if (!rst) begin
            if (sod || en || eod) begin
                n_vec++;
                if ((sod && en) || (eod && en) || (sod && eod)) begin
                    n_err++;
                    $display("FAIL strobe_overlap cycle=%0d got sod=%0b en=%0b eod=%0b required at most one",
                             cyc, sod, en, eod);
                end
            end
            if (!en) begin
                n_vec++;
                if (class_vec !== '0) begin
                    n_err++;
                    $display("FAIL idle_class cycle=%0d got class_vec=%h required 0", cyc, class_vec);
                end
            end
            if (sod) mon_pop(K_SOD, '0, "sod");
            if (en)  mon_pop(K_EN, class_vec, "class_vec");
            if (eod) mon_pop(K_EOD, NUM_CLASS'(pkt_len), "pkt_len");
        end
    end

    // Stimulus.
    initial begin
        logic [DATA_W-1:0] w;
        logic [LANES-1:0]  k;
        int                nw;
        int                sel;
        int                waited;

        rst      = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_free = cyc;

        // Single word "X-OSSpro", lane 0 = 'X'.
        w = "orpSSO-X";
        send_word(w, 8'hFF, 1'b1, 0);

        // Two-word packet, second word keep=0x07, valid held: pkt_len 11.
        w = {$urandom, $urandom};
        send_word(w, 8'hFF, 1'b0, 0);
        w = {$urandom, $urandom};
        send_word(w, 8'h07, 1'b1, 0);

        // Valid dropped 4 cycles between words; resume lane 0 = 'O'.
        w = {$urandom, $urandom};
        send_word(w, 8'hFF, 1'b0, 0);
        w = "zyx:-SXO";
        send_word(w, 8'hFF, 1'b1, 4);

        // Single 'O' byte.
        w = 64'h4F;
        send_word(w, 8'h01, 1'b1, 0);

        // Empty tlast word after a full word: pkt_len stays 8.
        w = {$urandom, $urandom};
        send_word(w, 8'hFF, 1'b0, 0);
        w = {$urandom, $urandom};
        send_word(w, 8'h00, 1'b1, 0);

        // Reset during lane 4: partial packet dropped, no eod.
        w = {$urandom, $urandom};
        send_word(w, 8'hFF, 1'b0, 0);
        while (cyc < last_lane0 + 4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        exp_q.delete();
        in_pkt  = 1'b0;
        cur_len = 0;
        @(negedge clk);
        check_zero("mid_packet_reset");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_free = cyc;
        w = {$urandom, $urandom};
        send_word(w, 8'hFF, 1'b1, 0);

        // Back-to-back one-byte packets.
        for (int i = 0; i < 3; i++) begin
            w = {$urandom, $urandom};
            send_word(w, 8'h01, 1'b1, 0);
        end

        // Random packets: 1-3 words, full/empty/sparse keep, random stalls.
        for (int p = 0; p < 24; p++) begin
            nw = $urandom_range(1, 3);
            for (int i = 0; i < nw; i++) begin
                w   = {$urandom, $urandom};
                sel = $urandom_range(0, 3);
                if (sel == 0)      k = 8'hFF;
                else if (sel == 1) k = 8'h00;
                else               k = 8'($urandom);
                send_word(w, k, (i == nw - 1), (i == 0) ? 0 : $urandom_range(0, 3));
            end
        end

        // Drain and look for stray events.
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        repeat (5) @(posedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending events required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
